// File: rtl/mul_div_execute.sv
// mul_div_execute: iterative RV32M multiply/divide unit for the execute stage.
// Multiplies by unsigned shift-add and divides by restoring shift-subtract on
// operand magnitudes, then fixes up the sign in a final cycle. Division by
// zero and signed overflow finish on the accepting edge.
module mul_div_execute #(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int ITER = WIDTH / STEPS_PER_CYCLE;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic [2:0]         op_r;
  logic               neg_a_r;
  logic               neg_b_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH-1:0] acc_r;

  logic               sign_a_s;
  logic               sign_b_s;
  logic [WIDTH-1:0]   a_abs_s;
  logic [WIDTH-1:0]   b_abs_s;
  logic               special_s;
  logic [WIDTH-1:0]   special_res_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_res_s;

  // One multiply step: add multiplicand into the high half if the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, x[2*WIDTH-1:WIDTH]} + (x[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, x[WIDTH-1:1]};
  endfunction

  // One restoring divide step: {remainder, quotient} shifts left, the divisor
  // is subtracted when it fits and the new quotient bit enters at the LSB.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0] t;
    t = {x[2*WIDTH-1:WIDTH], x[WIDTH-1]};
    if (t >= {1'b0, d}) begin
      t = t - {1'b0, d};
      return {t[WIDTH-1:0], x[WIDTH-2:0], 1'b1};
    end else begin
      return {t[WIDTH-1:0], x[WIDTH-2:0], 1'b0};
    end
  endfunction

  // Decode operand signedness, magnitudes and the fast-path special cases.
  always_comb begin
    sign_a_s      = 1'b0;
    sign_b_s      = 1'b0;
    special_s     = 1'b0;
    special_res_s = {WIDTH{1'b0}};
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sign_a_s = a[WIDTH-1];
        sign_b_s = b[WIDTH-1];
      end
      3'b010: begin
        sign_a_s = a[WIDTH-1];
        sign_b_s = 1'b0;
      end
      default: begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
      end
    endcase
    a_abs_s = sign_a_s ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    b_abs_s = sign_b_s ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
    if (funct3[2] && (b == {WIDTH{1'b0}})) begin
      special_s     = 1'b1;
      special_res_s = funct3[1] ? a : {WIDTH{1'b1}};
    end else if (funct3[2] && !funct3[0] && (a == MIN_NEG) && (b == {WIDTH{1'b1}})) begin
      special_s     = 1'b1;
      special_res_s = funct3[1] ? {WIDTH{1'b0}} : a;
    end else begin
      special_s     = 1'b0;
      special_res_s = {WIDTH{1'b0}};
    end
  end

  // Advance the accumulator by STEPS_PER_CYCLE multiply or divide steps.
  always_comb begin
    acc_next_s = acc_r;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (op_r[2]) begin
        acc_next_s = div_step(acc_next_s, opnd_r);
      end else begin
        acc_next_s = mul_step(acc_next_s, opnd_r);
      end
    end
  end

  // Sign correction and half select for the final result.
  always_comb begin
    prod_s = (neg_a_r ^ neg_b_r) ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
    if (!op_r[2]) begin
      fix_res_s = (op_r[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    end else if (!op_r[1]) begin
      fix_res_s = (neg_a_r ^ neg_b_r) ? (~acc_r[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                                      : acc_r[WIDTH-1:0];
    end else begin
      fix_res_s = neg_a_r ? (~acc_r[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                          : acc_r[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      op_r    <= 3'b000;
      neg_a_r <= 1'b0;
      neg_b_r <= 1'b0;
      opnd_r  <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= {WIDTH{1'b0}};
    end else begin
      done <= 1'b0;
      if (flush) begin
        state_r <= S_IDLE;
        cnt_r   <= {CW{1'b0}};
        ready   <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start && special_s) begin
              result <= special_res_s;
              done   <= 1'b1;
            end else if (start) begin
              op_r    <= funct3;
              neg_a_r <= sign_a_s;
              neg_b_r <= sign_b_s;
              opnd_r  <= funct3[2] ? b_abs_s : a_abs_s;
              acc_r   <= {{WIDTH{1'b0}}, (funct3[2] ? a_abs_s : b_abs_s)};
              cnt_r   <= CW'(ITER - 1);
              state_r <= S_CALC;
              ready   <= 1'b0;
              busy    <= 1'b1;
            end else begin
              state_r <= S_IDLE;
            end
          end
          S_CALC: begin
            acc_r <= acc_next_s;
            if (cnt_r == {CW{1'b0}}) begin
              state_r <= S_FIX;
            end else begin
              cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
          end
          S_FIX: begin
            result  <= fix_res_s;
            done    <= 1'b1;
            state_r <= S_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= S_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mul_div_execute.md
# mul_div_execute

Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage and handles the eight M-extension operations over multiple cycles. It accepts one operation through a ready/start handshake and reports completion with a one-cycle `done` pulse. While it is busy, the pipeline control holds the execute stage. Width and per-cycle radix are parameters.

## Interface
- `WIDTH`, 32: operand and result width in bits; must be even and at least 8.
- `STEPS_PER_CYCLE`, 1: quotient/product bits processed per cycle; must divide `WIDTH`. ITER = WIDTH/STEPS_PER_CYCLE.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; accepted only in a cycle where `ready`=1.
- `funct3`  in  3  operation select, sampled on accept:
  - 000 mul, 001 mulh, 010 mulhsu, 011 mulhu
  - 100 div, 101 divu, 110 rem, 111 remu
- `a`  in  WIDTH  rs1 operand (dividend / multiplicand), sampled on accept.
- `b`  in  WIDTH  rs2 operand (divisor / multiplier), sampled on accept.
- `flush`  in  1  synchronous abort of any in-flight operation.
- `ready`  out  1  unit idle, can accept `start`.
- `busy`  out  1  operation in flight; equals ~`ready`.
- `done`  out  1  one-cycle pulse: `result` valid this cycle.
- `result`  out  WIDTH  last completed result; held until the next completion.

## Operation
- States:
  - IDLE: `ready`=1.
  - CALC: down-counter `cnt` runs from ITER-1 to 0.
  - FIX: sign correction and hi/lo select.
- IDLE, `start`=1, `flush`=0:
  - Latch `funct3`, the absolute values of the operands, and the sign flags.
  - Go to CALC; the special-case fast path below bypasses CALC.
- CALC:
  - Multiply: unsigned shift-add, STEPS_PER_CYCLE multiplier bits per cycle, into a 2·WIDTH-bit accumulator.
  - Divide: restoring shift-subtract, STEPS_PER_CYCLE quotient bits per cycle, with a WIDTH-bit remainder.
  - When `cnt`=0, go to FIX.
- FIX:
  - Negate the product when the operand signs differ. Signs are taken as: mul/mulh both signed; mulhsu `a` signed only; mulhu neither.
  - Select product bits [WIDTH-1:0] for mul, else [2·WIDTH-1:WIDTH].
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (signed ops only).
  - Register `result`, pulse `done`, return to IDLE.
- Special cases (div/divu/rem/remu only) are detected at accept. They complete without CALC or FIX: `result` and `done` are registered on the accepting edge.
  - b=0: div/divu return all ones; rem/remu return `a`.
  - Signed overflow (a = 1 followed by WIDTH-1 zeros, b = all ones): div returns `a`; rem returns 0.
- Multiply never uses an early-out, so its latency is fixed.
- `flush`=1:
  - Next state is IDLE, `done` is not asserted, `result` keeps its previous value.
  - `flush` with `start` in the same cycle: flush wins and the start is dropped.
- Back-to-back: `start` may be asserted in the same cycle as `done`, because `ready`=1 then.

## Timing
- Reset (asynchronous, immediate): state IDLE; `ready`=1; `busy`=0; `done`=0; `result`=0; `cnt`=0; internal registers 0.
- Accept in cycle 0:
  - Cycles 1..ITER are CALC.
  - Cycle ITER+1 is FIX.
  - `done`=1 and `result` are valid in cycle ITER+2, together with `ready`=1.
  - WIDTH=32, S=1 gives `done` in cycle 34; S=4 gives cycle 10.
- Special case accepted in cycle 0: `done`=1 in cycle 1, and `ready` stays 1 throughout.
- `done` is high for exactly one cycle per completed operation and never without a prior accept.
- `flush` asserted in cycle k: `ready`=1 in cycle k+1.
- `rst` asserted mid-operation: outputs take their reset values immediately, with no `done`.

## Test plan
- mul, a=7, b=0xFFFFFFFD (−3), start in cycle 0 -> `done` in cycle 34, `result`=0xFFFFFFEB; `busy`=1 in cycles 1–33.
- mulh a=b=0x80000000 -> 0x40000000; mulhu a=b=0xFFFFFFFF -> 0xFFFFFFFE; mulhsu a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- div a=0xFFFFFFF9 (−7), b=2 -> 0xFFFFFFFD. rem with the same operands -> 0xFFFFFFFF. Issue the rem with `start` in the `done` cycle of the div; rem `done` follows 34 cycles later.
- divu 5/0 -> 0xFFFFFFFF with `done` in cycle 1. remu 5/0 -> 5. div 0x80000000 / 0xFFFFFFFF -> 0x80000000. rem with the same operands -> 0.
- Start div, assert `flush` in cycle 10 -> no `done`, `ready`=1 in cycle 11, `result` unchanged. Assert `flush` and `start` together -> nothing accepted.
- STEPS_PER_CYCLE=4: divu 100/7 -> 14 with `done` in cycle 10. Assert `rst` in cycle 5 of a new op -> `busy`=0 and `result`=0 immediately, no `done`.
